// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module   : data_memory
// Brief    : RV32I data memory with byte/half/word access, sign/zero
//            extension, per-byte write masking, alignment/encoding fault
//            detection, registered read response and post-reset zero-sweep.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int WORDS = 64,
    parameter int IDX_W = $clog2(WORDS)
) (
    input  logic        clk,
    input  logic        rst_en,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        rsp_valid,
    output logic [31:0] read_data,
    output logic        fault,
    output logic        init_done
);

    localparam logic [0:0] c_ST_INIT  = 1'b0;
    localparam logic [0:0] c_ST_READY = 1'b1;
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(WORDS - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [IDX_W-1:0] r_sweep_idx;
    logic [IDX_W-1:0] w_sweep_nxt;
    logic [31:0]      r_mem [WORDS];

    logic             r_rsp_valid;
    logic [31:0]      r_read_data;
    logic             r_fault;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic             w_illegal;
    logic             w_misalign;
    logic             w_fault;
    logic [3:0]       w_mask;
    logic [31:0]      w_wdata;
    logic [31:0]      w_word;
    logic [31:0]      w_shifted;
    logic [31:0]      w_load;
    logic             w_unused;

    // Upper address bits only alias; they carry no meaning here.
    assign w_unused  = ^address[31:IDX_W+2];

    assign req_ready = (r_state == c_ST_READY);
    assign init_done = (r_state == c_ST_READY);
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = address[IDX_W+1:2];
    assign w_lane    = address[1:0];
    assign w_word    = r_mem[w_idx];
    assign w_shifted = w_word >> {w_lane, 3'b000};
    assign w_fault   = w_illegal || w_misalign;

    assign rsp_valid = r_rsp_valid;
    assign read_data = r_read_data;
    assign fault     = r_fault;

    // State and sweep-counter register.
    always_ff @(posedge clk or posedge rst_en) begin
        if (rst_en) begin
            r_state     <= c_ST_INIT;
            r_sweep_idx <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sweep_idx <= w_sweep_nxt;
        end
    end

    // Next state: sweep every word once, then serve requests forever.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep_idx;
        case (r_state)
            c_ST_INIT: begin
                w_sweep_nxt = r_sweep_idx + IDX_W'(1);
                if (r_sweep_idx == c_LAST_IDX) begin
                    w_state_nxt = c_ST_READY;
                    w_sweep_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    // Request decode: legality, alignment, lane mask and replicated data.
    always_comb begin
        if (req_write) begin
            w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        w_misalign = ((req_funct3[1:0] == 2'b01) && address[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (address[1:0] != 2'b00));
        case (req_funct3[1:0])
            2'b00: begin
                w_mask  = 4'b0001 << w_lane;
                w_wdata = {4{write_data[7:0]}};
            end
            2'b01: begin
                w_mask  = 4'b0011 << w_lane;
                w_wdata = {2{write_data[15:0]}};
            end
            default: begin
                w_mask  = 4'b1111;
                w_wdata = write_data;
            end
        endcase
    end

    // Load alignment and sign/zero extension of the selected bytes.
    always_comb begin
        case (req_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'b0, w_shifted[7:0]};
            3'b101:  w_load = {16'b0, w_shifted[15:0]};
            default: w_load = w_word;
        endcase
    end

    // Array write: zero-sweep during init, masked stores afterwards.
    always_ff @(posedge clk) begin
        if (r_state == c_ST_INIT) begin
            r_mem[r_sweep_idx] <= '0;
        end else if (w_accept && req_write && !w_fault) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered response; data and fault hold between responses.
    always_ff @(posedge clk or posedge rst_en) begin
        if (rst_en) begin
            r_rsp_valid <= 1'b0;
            r_read_data <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_fault     <= w_fault;
                r_read_data <= (req_write || w_fault) ? 32'd0 : w_load;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory
// Brief    : Self-checking bench for data_memory: byte-array reference model
//            compared every cycle, plus literal expectations on key accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    localparam int c_WORDS = 64;
    localparam int c_BYTES = 4 * c_WORDS;

    logic        clk = 1'b0;
    logic        rst_en = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] address = 32'b0;
    logic [31:0] write_data = 32'b0;
    logic        rsp_valid;
    logic [31:0] read_data;
    logic        fault;
    logic        init_done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model state.
    logic [7:0]  m_bytes [c_BYTES];
    int          m_cnt = 0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_data = 32'b0;
    logic        exp_fault = 1'b0;

    data_memory #(.WORDS(c_WORDS)) dut (
        .clk        (clk),
        .rst_en     (rst_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .address    (address),
        .write_data (write_data),
        .rsp_valid  (rsp_valid),
        .read_data  (read_data),
        .fault      (fault),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural view of one access on a flat little-endian byte array.
    function automatic void model_access(input bit w, input logic [2:0] f3,
                                         input logic [31:0] a, input logic [31:0] d,
                                         output logic [31:0] rd, output logic flt);
        int ba;
        int n;
        bit legal;
        logic [31:0] v;
        ba    = int'(a % c_BYTES);
        legal = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 1 << f3[1:0];
        flt   = !legal || ((ba % n) != 0);
        rd    = 32'd0;
        if (!flt && w) begin
            for (int i = 0; i < n; i++) m_bytes[ba + i] = d[8*i +: 8];
        end else if (!flt) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v = v | (32'(m_bytes[ba + i]) << (8 * i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            rd = v;
        end
    endfunction

    // Reference model: ready after WORDS edges, one response per accept.
    always @(posedge clk or posedge rst_en) begin
        if (rst_en) begin
            m_cnt     = 0;
            exp_valid = 1'b0;
            exp_data  = 32'd0;
            exp_fault = 1'b0;
            for (int i = 0; i < c_BYTES; i++) m_bytes[i] = 8'd0;
        end else begin
            exp_valid = 1'b0;
            if (m_cnt >= c_WORDS) begin
                if (req_valid) begin
                    exp_valid = 1'b1;
                    model_access(req_write, req_funct3, address, write_data, exp_data, exp_fault);
                end
            end else begin
                m_cnt++;
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), 32'(m_cnt >= c_WORDS));
            chk("init_done", 32'(init_done), 32'(m_cnt >= c_WORDS));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            chk("read_data", read_data, exp_data);
            chk("fault",     32'(fault), 32'(exp_fault));
        end
    end

    task automatic drive(input bit w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        address    = a;
        write_data = d;
    endtask

    // One request with a hand-computed expected response.
    task automatic lit(input string name, input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] ed, input logic ef);
        drive(w, f3, a, d);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({name, "_data"}, read_data, ed);
        chk({name, "_fault"}, 32'(fault), 32'(ef));
    endtask

    // Release reset and count edges until the block becomes ready.
    task automatic release_and_wait(input string name);
        int n;
        n = 0;
        rst_en = 1'b0;
        while (!req_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_edges"}, 32'(n), 32'(c_WORDS));
        chk({name, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_data", read_data, 32'd0);
        release_and_wait("init");
        for (int i = 0; i < c_WORDS; i++) lit("init_lw", 1'b0, 3'd2, 32'(i << 2), 32'd0, 32'd0, 1'b0);

        lit("sw0", 1'b1, 3'd2, 32'h0, 32'hDEADBEEF, 32'd0, 1'b0);
        lit("lw0", 1'b0, 3'd2, 32'h0, 32'd0, 32'hDEADBEEF, 1'b0);
        lit("lb3", 1'b0, 3'd0, 32'h3, 32'd0, 32'hFFFFFFDE, 1'b0);
        lit("lbu3", 1'b0, 3'd4, 32'h3, 32'd0, 32'h000000DE, 1'b0);
        lit("lh2", 1'b0, 3'd1, 32'h2, 32'd0, 32'hFFFFDEAD, 1'b0);
        lit("lhu0", 1'b0, 3'd5, 32'h0, 32'd0, 32'h0000BEEF, 1'b0);

        lit("sw4", 1'b1, 3'd2, 32'h4, 32'h11223344, 32'd0, 1'b0);
        lit("sb5", 1'b1, 3'd0, 32'h5, 32'h000000AA, 32'd0, 1'b0);
        lit("sh6", 1'b1, 3'd1, 32'h6, 32'h0000BBCC, 32'd0, 1'b0);
        lit("lw4", 1'b0, 3'd2, 32'h4, 32'd0, 32'hBBCCAA44, 1'b0);

        lit("lw6_mis", 1'b0, 3'd2, 32'h6, 32'd0, 32'd0, 1'b1);
        lit("sh3_mis", 1'b1, 3'd1, 32'h3, 32'h0000FFFF, 32'd0, 1'b1);
        lit("lw0_keep", 1'b0, 3'd2, 32'h0, 32'd0, 32'hDEADBEEF, 1'b0);
        lit("ld_f3_011", 1'b0, 3'd3, 32'h0, 32'd0, 32'd0, 1'b1);
        lit("st_f3_100", 1'b1, 3'd4, 32'h0, 32'h12345678, 32'd0, 1'b1);
        lit("lw0_keep2", 1'b0, 3'd2, 32'h0, 32'd0, 32'hDEADBEEF, 1'b0);

        // Back-to-back store then load bursts; the per-cycle compare checks each.
        for (int i = 0; i < c_WORDS; i++) begin
            drive(1'b1, 3'd2, 32'(i << 2), 32'(i * 100));
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < c_WORDS; i++) begin
            drive(1'b0, 3'd2, 32'(i << 2), 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        lit("alias_100", 1'b0, 3'd2, 32'h100, 32'd0, 32'd0, 1'b0);
        lit("lw_fc", 1'b0, 3'd2, 32'hFC, 32'd0, 32'd6300, 1'b0);
        lit("alias_hi", 1'b0, 3'd2, 32'hABCD_0104, 32'd0, 32'd100, 1'b0);

        // Randomized traffic.
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] a;
            logic [2:0]  f3;
            a  = $urandom;
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1 && f3 inside {3'd0, 3'd1}) f3[2] = 1'b1;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            drive($urandom_range(0, 1) == 1, f3, a, $urandom);
            req_valid = ($urandom_range(0, 4) != 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;

        // Reset in the middle of a store burst.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 3'd2, 32'(i << 2), 32'hA5A5_0000 | 32'(i));
            @(posedge clk);
            #1;
            if (i == 10) break;
        end
        chk("pre_rst_rsp", 32'(rsp_valid), 32'd1);
        rst_en = 1'b1;
        #1;
        chk("midrst_rsp", 32'(rsp_valid), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_data", read_data, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        release_and_wait("reinit");
        for (int i = 0; i < c_WORDS; i++) lit("reinit_lw", 1'b0, 3'd2, 32'(i << 2), 32'd0, 32'd0, 1'b0);

        // Reset again mid-sweep: sweep must restart from the top.
        rst_en = 1'b1;
        @(posedge clk);
        #1;
        rst_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_en = 1'b1;
        @(posedge clk);
        #1;
        release_and_wait("resweep");

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_memory.md
# data_memory

Parametrised RV32I data memory that replaces the fixed word-only memory in the load/store path. It supports byte, half-word and word accesses with sign/zero extension, per-byte write masking, and alignment/encoding fault detection. It also provides a registered read with a valid/ready request interface and a hardware zero-sweep after reset. It sits between the core's memory stage and the testbench/system bus.

## Interface
Parameters:
- WORDS, 64, number of 32-bit words; power of two, ≥ 2
- IDX_W, $clog2(WORDS), word-index width (derived; not overridden)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_en  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 size/sign code
- address  in  32  byte address
- write_data  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response pulse
- read_data  out  32  load result, extended to 32 bits
- fault  out  1  qualified by rsp_valid; misaligned or illegal funct3
- init_done  out  1  zero-sweep complete

## Operation
- States: INIT, READY.
- INIT: a sweep counter writes 0 to word sweep_idx each cycle, from 0 to WORDS-1. The block moves to READY on the edge that writes word WORDS-1. req_ready = 0 and init_done = 0 throughout INIT.
- READY: req_ready = 1 every cycle; full throughput of one request per cycle; no backpressure on responses.
- Accept = req_valid && req_ready. Word index = address[IDX_W+1:2]. Upper address bits are ignored, so addresses alias modulo 4*WORDS.
- Byte order is little-endian. Byte lane = address[1:0].
- Legal funct3 values:
  - Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Store: 000 SB, 001 SH, 010 SW.
- fault = 1 in any of these cases: illegal funct3 for the direction; half access with address[0] ≠ 0; word access with address[1:0] ≠ 0.
- A faulting store writes nothing. A faulting load returns read_data = 0.
- Store: on the accept edge, only the addressed lanes are written (byte mask 0001<<lane, 0011<<lane or 1111). The store data byte/half is replicated into the target lane(s).
- Load: on the accept edge, the selected bytes are shifted to bit 0 and extended, then registered into read_data. LB/LH sign-extend; LBU/LHU zero-extend.
- Store response: rsp_valid pulses with read_data = 0 and fault set per the rules above.

## Timing
- Reset values: req_ready 0, rsp_valid 0, read_data 0, fault 0, init_done 0, sweep_idx 0, state INIT. Array contents are not reset directly; the sweep clears them.
- After rst_en falls, req_ready rises after exactly WORDS rising edges.
- Response latency: rsp_valid, read_data and fault are valid in the cycle after the accept edge, for one cycle. With no accept, rsp_valid = 0 and read_data/fault hold their last values.
- Store followed by a load to the same word in the next cycle: the load returns the new data. There is no forwarding hazard.
- rst_en asserted at any time, including mid-sweep or mid-burst:
  - Outputs go to reset values immediately (asynchronously).
  - Any pending response is dropped.
  - The sweep restarts from word 0, and the memory reads all-zero once init_done rises.
- req_* inputs are ignored while req_ready = 0. No request is queued.

## Test plan
- Reset/init (WORDS = 64): pulse rst_en → req_ready 0 for exactly 64 edges, then 1, with init_done = 1. An LW of every word i<<2 → read_data 0, fault 0.
- Sizes/extension: SW 0x0 ← 0xDEADBEEF, then:
  - LW 0x0 → 0xDEADBEEF, one cycle after accept.
  - LB 0x3 → 0xFFFFFFDE; LBU 0x3 → 0x000000DE.
  - LH 0x2 → 0xFFFFDEAD; LHU 0x0 → 0x0000BEEF.
- Byte masking: SW 0x4 ← 0x11223344; SB 0x5 ← 0x000000AA; SH 0x6 ← 0x0000BBCC → LW 0x4 = 0xBBCCAA44.
- Faults:
  - LW 0x6 → fault 1, read_data 0.
  - SH 0x3 ← 0xFFFF → fault 1, and LW 0x0 is unchanged.
  - Load funct3 011 → fault 1; store funct3 100 → fault 1.
- Burst/alias: back-to-back SW to word i (i = 0..63, data i*100), then back-to-back LW → one rsp_valid per cycle, each matching. LW 0x100 returns the word-0 value.
- Reset mid-burst: assert rst_en during the store burst → rsp_valid 0 in the same cycle, req_ready 0, re-sweep of 64 cycles. All words then read 0.
